// File: rtl/speck_key_schedule.sv
// SPECK-128/128 key schedule: expands a 128-bit master key into ROUNDS subkeys, one per valid/ready transfer.
// Optional subkey cache for reverse-order readback is enabled by defining SPECK_KS_CACHE_EN.
//
// state  | meaning
// IDLE   | waiting for signal_start
// LOAD   | capture master key into k/l, i = 0
// EMIT   | subkey k presented with valid, waiting for ready
// EXPAND | compute next l and k from the current pair
// DONE   | finished pulse, back to IDLE
module speck_key_schedule #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_start,
    input  logic [127:0] key,
    output logic [63:0]  subkey,
    output logic         subkey_valid,
    input  logic         subkey_ready,
    output logic [4:0]   round_index,
    output logic         finished,
    output logic [3:0]   state_response
`ifdef SPECK_KS_CACHE_EN
    ,
    input  logic [4:0]   cache_addr,
    output logic [63:0]  cache_data,
    output logic         cache_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EMIT   = 3'd2,
        EXPAND = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS - 1);

    state_t      state;
    logic [63:0] l_q;
    logic [63:0] l_next;
    logic [63:0] k_next;
    logic        last_xfer;

    assign state_response = {1'b0, state};
    assign last_xfer      = (state == EMIT) && subkey_ready && (round_index == LAST);

    // subkey doubles as the k register; l_next feeds k_next in the same cycle
    always_comb begin
        l_next = (subkey + {l_q[7:0], l_q[63:8]}) ^ {59'b0, round_index};
        k_next = {subkey[60:0], subkey[63:61]} ^ l_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            subkey       <= '0;
            l_q          <= '0;
            round_index  <= '0;
            subkey_valid <= 1'b0;
            finished     <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (signal_start) state <= LOAD;
                end
                LOAD: begin
                    subkey       <= key[63:0];
                    l_q          <= key[127:64];
                    round_index  <= '0;
                    subkey_valid <= 1'b1;
                    state        <= EMIT;
                end
                EMIT: begin
                    if (subkey_ready) begin
                        subkey_valid <= 1'b0;
                        if (round_index == LAST) begin
                            finished <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    subkey       <= k_next;
                    l_q          <= l_next;
                    round_index  <= round_index + 5'd1;
                    subkey_valid <= 1'b1;
                    state        <= EMIT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPECK_KS_CACHE_EN
    logic [63:0] cache_mem [ROUNDS];

    always_ff @(posedge clk) begin
        if (state == EMIT && subkey_ready) cache_mem[round_index] <= subkey;
    end

    // valid rises together with finished so a read issued in DONE already hits
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_data  <= '0;
        end else begin
            if (state == IDLE && signal_start) cache_valid <= 1'b0;
            else if (last_xfer)                cache_valid <= 1'b1;
            if (cache_valid && ({1'b0, cache_addr} < 6'(ROUNDS)))
                cache_data <= cache_mem[cache_addr];
            else
                cache_data <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_speck_key_schedule.sv
// Directed scoreboard bench for speck_key_schedule: golden subkeys are queued at start and popped on each transfer.
module tb_speck_key_schedule;

    localparam int ROUNDS = 32;
    localparam logic [127:0] TK = 128'h0f0e0d0c0b0a0908_0706050403020100;

    logic         clk = 1'b0;
    logic         rst;
    logic         signal_start;
    logic [127:0] key;
    logic [63:0]  subkey;
    logic         subkey_valid;
    logic         subkey_ready;
    logic [4:0]   round_index;
    logic         finished;
    logic [3:0]   state_response;
`ifdef SPECK_KS_CACHE_EN
    logic [4:0]   cache_addr;
    logic [63:0]  cache_data;
    logic         cache_valid;
`endif

    speck_key_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk            (clk),
        .rst            (rst),
        .signal_start   (signal_start),
        .key            (key),
        .subkey         (subkey),
        .subkey_valid   (subkey_valid),
        .subkey_ready   (subkey_ready),
        .round_index    (round_index),
        .finished       (finished),
        .state_response (state_response)
`ifdef SPECK_KS_CACHE_EN
        ,
        .cache_addr     (cache_addr),
        .cache_data     (cache_data),
        .cache_valid    (cache_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] k;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [63:0] gold [ROUNDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void golden(input logic [127:0] mk);
        logic [63:0] k, l;
        k = mk[63:0];
        l = mk[127:64];
        for (int r = 0; r < ROUNDS; r++) begin
            gold[r] = k;
            l = (k + ((l >> 8) | (l << 56))) ^ 64'(r);
            k = ((k << 3) | (k >> 61)) ^ l;
        end
    endfunction

    // Called at a negedge. mode 0: ready held 1; 1: random ready; 2: ready 1 plus key change and stray start.
    task automatic run_schedule(input logic [127:0] mk, input int mode, input int abort_idx,
                                output int first_cyc, output int fin_cyc, output int fin_cnt);
        int   cyc;
        int   tail;
        logic rdy;
        first_cyc = -1;
        fin_cyc   = -1;
        fin_cnt   = 0;
        tail      = 0;
        golden(mk);
        sb.delete();
        for (int r = 0; r < ROUNDS; r++) sb.push_back('{idx: 5'(r), k: gold[r]});
        if (mk == TK) begin
            sb[0].k = 64'h0706050403020100;
            sb[1].k = 64'h37253b31171d0309;
        end
        key          = mk;
        signal_start = 1'b1;
        @(negedge clk);
        signal_start = 1'b0;
        cyc          = 0;
        forever begin
            if (mode == 2 && cyc == 1) key = {mk[63:0], mk[127:64]} ^ 128'h5555_aaaa_1234_5678_9abc_def0_0f0f_f0f0;
            if (mode == 2) signal_start = (cyc == 4 || cyc == 9);
            if (sb.size() == 0) begin
                check("no_extra_valid", 64'(subkey_valid), 64'd0);
            end else if (subkey_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (abort_idx >= 0 && int'(sb[0].idx) == abort_idx) return;
                check("subkey", subkey, sb[0].k);
                check("round_index", 64'(round_index), 64'(sb[0].idx));
                check("state_emit", 64'(state_response), 64'd2);
            end
            if (finished) begin
                fin_cnt++;
                fin_cyc = cyc;
            end else if (sb.size() != 0) begin
                check("no_early_finish", 64'(finished), 64'd0);
            end
            rdy          = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            subkey_ready = rdy;
            if (subkey_valid && rdy && sb.size() != 0) void'(sb.pop_front());
            if (sb.size() == 0 && fin_cnt > 0) tail++;
            if (tail >= 4) break;
            if (cyc >= 2000) begin
                checks++;
                assert (sb.size() == 0) else begin
                    errors++;
                    $error("FAIL timeout: observed %0d outstanding expected 0", sb.size());
                end
                break;
            end
            @(negedge clk);
            cyc++;
        end
        signal_start = 1'b0;
    endtask

    int first_cyc, fin_cyc, fin_cnt;

    initial begin
        rst          = 1'b1;
        signal_start = 1'b0;
        subkey_ready = 1'b0;
        key          = TK;
`ifdef SPECK_KS_CACHE_EN
        cache_addr   = 5'd1;
`endif
        repeat (3) @(negedge clk);
        check("rst_subkey", subkey, 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_index", 64'(round_index), 64'd0);
        check("rst_finished", 64'(finished), 64'd0);
        check("rst_state", 64'(state_response), 64'd0);
`ifdef SPECK_KS_CACHE_EN
        check("rst_cache_valid", 64'(cache_valid), 64'd0);
        check("rst_cache_data", cache_data, 64'd0);
`endif
        rst = 1'b0;

        // ready in IDLE must not start anything
        subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_state", 64'(state_response), 64'd0);
        check("idle_ready_valid", 64'(subkey_valid), 64'd0);

        // ready held high: first valid one edge after LOAD, finished 2*ROUNDS edges after start
        run_schedule(TK, 0, -1, first_cyc, fin_cyc, fin_cnt);
        check("first_valid_cycle", 64'(first_cyc), 64'd1);
        check("finished_count", 64'(fin_cnt), 64'd1);
        check("finished_cycle", 64'(fin_cyc), 64'(2 * ROUNDS));
        check("end_state_idle", 64'(state_response), 64'd0);
`ifdef SPECK_KS_CACHE_EN
        check("cache_valid", 64'(cache_valid), 64'd1);
        check("cache_k1", cache_data, 64'h37253b31171d0309);
        cache_addr = 5'd31;
        @(negedge clk);
        check("cache_k31", cache_data, gold[31]);
        cache_addr = 5'd1;
`endif

        // random backpressure
        run_schedule(128'h1918111009080100_0123456789abcdef, 1, -1, first_cyc, fin_cyc, fin_cnt);
        check("bp_finished_count", 64'(fin_cnt), 64'd1);

        // key changed after LOAD and stray start pulses ignored
        run_schedule(TK, 2, -1, first_cyc, fin_cyc, fin_cnt);
        check("disturb_finished_count", 64'(fin_cnt), 64'd1);
        check("disturb_finished_cycle", 64'(fin_cyc), 64'(2 * ROUNDS));

        // reset while EMIT holds round 10, with start high in the same cycle
        run_schedule(TK, 0, 10, first_cyc, fin_cyc, fin_cnt);
        check("pre_abort_valid", 64'(subkey_valid), 64'd1);
        check("pre_abort_index", 64'(round_index), 64'd10);
        rst          = 1'b1;
        signal_start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_state", 64'(state_response), 64'd0);
        check("abort_finished", 64'(finished), 64'd0);
        check("abort_subkey", subkey, 64'd0);
`ifdef SPECK_KS_CACHE_EN
        check("abort_cache_valid", 64'(cache_valid), 64'd0);
`endif
        rst          = 1'b0;
        signal_start = 1'b0;
        @(negedge clk);
        check("post_abort_state", 64'(state_response), 64'd0);
        check("post_abort_valid", 64'(subkey_valid), 64'd0);

        run_schedule(TK, 0, -1, first_cyc, fin_cyc, fin_cnt);
        check("restart_first_cycle", 64'(first_cyc), 64'd1);
        check("restart_finished_count", 64'(fin_cnt), 64'd1);
        check("restart_finished_cycle", 64'(fin_cyc), 64'(2 * ROUNDS));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
